// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
// ---------------------------------------------------------------------------
// Terminating UART receiver: decodes one sniffed serial line (8 data bits,
// LSB first, optional parity, 1 stop bit) into bytes with error flags for the
// logging / LED / hex-display logic.
//
// Ports
//   CLOCK_50       in   system clock, all logic on the rising edge
//   RESET_N        in   asynchronous active-low reset
//   RXD            in   serial input, asynchronous to CLOCK_50, idle high
//   DATA           out  [7:0] last received byte, held until next DATA_VALID
//   DATA_VALID     out  1-cycle pulse: DATA updated, stop bit good
//   PARITY_ERROR   out  1-cycle pulse with DATA_VALID when parity mismatched
//   FRAMING_ERROR  out  1-cycle pulse when the stop bit is sampled low
//   BUSY           out  high whenever the receiver is not IDLE
//   STATE_DBG      out  [2:0] current FSM state
//                       0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK
//
// Handshake: there is no ready input. DATA_VALID (or FRAMING_ERROR) is a
// single-cycle strobe; the consumer must capture DATA within one frame time,
// after which it is overwritten without notice.
// ---------------------------------------------------------------------------
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 434,  // CLOCK_50 cycles per bit, >= 4
  parameter int PARITY       = 0     // 0 none, 1 odd, 2 even
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       PARITY_ERROR,
  output logic       FRAMING_ERROR,
  output logic       BUSY,
  output logic [2:0] STATE_DBG
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             par_err;
  logic             par_exp;

  // per-cycle strobes from the FSM to the datapath
  logic             frame_begin;
  logic             shift_en;
  logic             par_sample;
  logic             valid_set;
  logic             ferr_set;

  // Two-flop synchronizer; reset to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx_s    <= rx_meta;
    end
  end

  // Expected parity bit for the byte currently in the shift register.
  assign par_exp = (PARITY == 1) ? ~^shift_reg : ^shift_reg;

  // Next-state logic. bit_cnt is cleared on every state entry and whenever a
  // full bit period has elapsed inside DATA.
  always_comb begin
    state_next  = state;
    cnt_next    = bit_cnt + 1'b1;
    frame_begin = 1'b0;
    shift_en    = 1'b0;
    par_sample  = 1'b0;
    valid_set   = 1'b0;
    ferr_set    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next  = S_START;
          frame_begin = 1'b1;
        end
      end
      S_START: begin
        // Re-check the line at the middle of the start bit.
        if (bit_cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_cnt == CNT_LAST) begin
          cnt_next = '0;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_cnt == CNT_LAST) begin
          cnt_next   = '0;
          par_sample = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
        if (bit_cnt == CNT_LAST) begin
          cnt_next   = '0;
          valid_set  = rx_s;
          ferr_set   = ~rx_s;
          state_next = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line must go high before another frame is accepted.
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  // Datapath: shift register, bit index and latched parity mismatch.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      par_err   <= 1'b0;
    end else begin
      if (state == S_START) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end
      if (frame_begin) begin
        par_err <= 1'b0;
      end else if (par_sample && (PARITY != 0)) begin
        par_err <= (rx_s != par_exp);
      end
    end
  end

  // Registered outputs: pulses appear the cycle after the stop-bit sample.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA          <= 8'h00;
      DATA_VALID    <= 1'b0;
      PARITY_ERROR  <= 1'b0;
      FRAMING_ERROR <= 1'b0;
    end else begin
      DATA_VALID    <= valid_set;
      PARITY_ERROR  <= valid_set & par_err;
      FRAMING_ERROR <= ferr_set;
      if (valid_set) begin
        DATA <= shift_reg;
      end
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor
// ---------------------------------------------------------------------------
// Bench for uart_rx_monitor with CLKS_PER_BIT=8. Two instances share clock
// and reset: dut0 without parity, dut2 with even parity. Frames are built
// from a byte, a parity bit and a stop bit; a frame-level model predicts the
// event (byte received or framing error) each frame must produce.
// ---------------------------------------------------------------------------
module tb_uart_rx_monitor;

  localparam int CPB = 8;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       rxd0, rxd2;
  logic [7:0] data0, data2;
  logic       dv0, dv2, pe0, pe2, fe0, fe2, busy0, busy2;
  logic [2:0] st0, st2;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .RXD(rxd0),
    .DATA(data0), .DATA_VALID(dv0), .PARITY_ERROR(pe0),
    .FRAMING_ERROR(fe0), .BUSY(busy0), .STATE_DBG(st0)
  );

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .RXD(rxd2),
    .DATA(data2), .DATA_VALID(dv2), .PARITY_ERROR(pe2),
    .FRAMING_ERROR(fe2), .BUSY(busy2), .STATE_DBG(st2)
  );

  // ---------------- clock / reset ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // event word: {dut, kind[1:0] = {framing, valid}, parity_error, data}
  logic [11:0] exp_q[$];

  typedef struct {
    int          cyc;
    logic [11:0] ev;
  } obs_t;
  obs_t obs_q[$];
  int   rd = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] last_data [2];

  // Every cycle with any pulse high becomes one observed event, so a pulse
  // wider than one cycle shows up as an extra event.
  always @(negedge CLOCK_50) begin
    if (dv0 || fe0) obs_q.push_back('{cyc, {1'b0, fe0, dv0, pe0, data0}});
    if (dv2 || fe2) obs_q.push_back('{cyc, {1'b1, fe2, dv2, pe2, data2}});
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: what a frame with these bits must produce.
  function automatic logic [11:0] model(input bit d, input logic [7:0] b,
                                        input logic par_bit,
                                        input logic stop_bit);
    int   ones;
    logic good_par;
    logic perr;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    good_par = ((ones % 2) == 1);       // even parity: total count even
    perr     = d && (par_bit != good_par);
    if (stop_bit) begin
      last_data[d] = b;
      return {d, 2'b01, perr, b};
    end
    return {d, 2'b10, 1'b0, last_data[d]};
  endfunction

  // Drain all expected events against the observed ones.
  task automatic check_events(input string tag);
    logic [11:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_present"}, 32'(rd < obs_q.size()), 32'd1);
      if (rd < obs_q.size()) begin
        check({tag, "_event"}, 32'(obs_q[rd].ev), 32'(e));
        rd++;
      end
    end
    check({tag, "_no_extra"}, 32'(obs_q.size()), 32'(rd));
  endtask

  // ---------------- driver ----------------
  task automatic set_line(input bit d, input logic v);
    if (d) rxd2 = v;
    else   rxd0 = v;
  endtask

  task automatic drive_bit(input bit d, input logic v);
    set_line(d, v);
    repeat (CPB) @(negedge CLOCK_50);
  endtask

  task automatic idle(input bit d, input int n);
    set_line(d, 1'b1);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input bit d, input logic [7:0] b,
                            input logic par_bit, input logic stop_bit,
                            output int t0);
    exp_q.push_back(model(d, b, par_bit, stop_bit));
    t0 = cyc;
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, b[i]);
    if (d) drive_bit(d, par_bit);
    drive_bit(d, stop_bit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          t0, t1, diff;
    bit          d;
    logic [7:0]  b;
    logic        pb, sb;

    RESET_N = 1'b0;
    rxd0 = 1'b1;
    rxd2 = 1'b1;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    repeat (4) @(negedge CLOCK_50);
    check("rst_data0", 32'(data0), 32'h00);
    check("rst_pulses0", 32'({dv0, pe0, fe0, busy0}), 32'h0);
    check("rst_pulses2", 32'({dv2, pe2, fe2, busy2, data2}), 32'h0);
    check("rst_state0", 32'(st0), 32'd0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLOCK_50);

    // single good frame plus latency
    send_frame(0, 8'hA5, 1'b0, 1'b1, t0);
    idle(0, 4);
    check_events("a5");
    if (rd >= 1) begin
      diff = obs_q[rd-1].cyc - t0;
      check("a5_latency", 32'(diff >= 78 && diff <= 80), 32'd1);
    end
    check("a5_busy_after", 32'(busy0), 32'd0);
    check("a5_data_hold", 32'(data0), 32'hA5);

    // back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b1, t0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, t1);
    idle(0, 4);
    check_events("b2b");
    if (rd >= 2) begin
      diff = obs_q[rd-1].cyc - obs_q[rd-2].cyc;
      check("b2b_spacing", 32'(diff >= 79 && diff <= 81), 32'd1);
    end

    // 3-cycle glitch must be rejected
    set_line(0, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    set_line(0, 1'b1);
    repeat (8) @(negedge CLOCK_50);
    check("glitch_busy", 32'(busy0), 32'd0);
    check("glitch_state", 32'(st0), 32'd0);
    idle(0, 4);
    check_events("glitch");

    // framing error followed by a break, then a good frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, t0);
    repeat (40) @(negedge CLOCK_50);
    check("break_busy", 32'(busy0), 32'd1);
    idle(0, 6);
    check_events("ferr");
    check("ferr_data_kept", 32'(data0), 32'hFF);
    check("ferr_busy_after", 32'(busy0), 32'd0);
    send_frame(0, 8'h11, 1'b0, 1'b1, t0);
    idle(0, 4);
    check_events("after_ferr");

    // even parity: good then bad parity bit
    send_frame(1, 8'h03, 1'b0, 1'b1, t0);
    idle(1, 4);
    check_events("par_good");
    send_frame(1, 8'h03, 1'b1, 1'b1, t0);
    idle(1, 4);
    check_events("par_bad");
    check("par_data", 32'(data2), 32'h03);

    // randomized frames on both instances
    for (int n = 0; n < 24; n++) begin
      d  = bit'($urandom_range(0, 1));
      b  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, b, pb, sb, t0);
      if (!sb) begin
        repeat ($urandom_range(0, 20)) @(negedge CLOCK_50);
        idle(d, 3 + $urandom_range(0, 4));
      end else begin
        idle(d, $urandom_range(1, 6));
      end
      check_events("rand");
      check("rand_data0", 32'(data0), 32'(last_data[0]));
      check("rand_data2", 32'(data2), 32'(last_data[1]));
    end

    // reset in the middle of data bit 4 of 8'h5A
    b = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, b[i]);
    set_line(0, b[4]);
    repeat (CPB / 2) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    rxd0 = 1'b1;
    #1;
    check("midrst_outputs0", 32'({data0, dv0, pe0, fe0, busy0}), 32'h0);
    check("midrst_outputs2", 32'({data2, dv2, pe2, fe2, busy2}), 32'h0);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    idle(0, 20);
    check_events("midrst");
    check("midrst_state", 32'(st0), 32'd0);
    send_frame(0, 8'h77, 1'b0, 1'b1, t0);
    idle(0, 4);
    check_events("post_rst");
    check("post_rst_data", 32'(data0), 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
